fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
- Round-robin burst arbiter that drains NREQ first-word-fall-through request FIFOs into one registered valid/ready output stream.
- Each request FIFO presents `empty`/`dout` and takes a `rden` pop strobe.
- Sits between per-source command/data FIFOs and a single shared consumer, e.g. a host-interface write path.
- A grant holds for up to MAX_BURST words, then rotates to the next requester.

Parameters:
- NREQ, 4: number of requester FIFOs (2..8).
- SRCW, 2: width of the source index; must equal ceil(log2(NREQ)).
- WIDTH, 32: data word width.
- MAX_BURST, 8: maximum words per grant (1..256).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_empty  in  NREQ  per-FIFO empty flag; bit i belongs to requester i.
- req_dout  in  NREQ*WIDTH  per-FIFO head word; requester i occupies bits [i*WIDTH +: WIDTH].
- req_rden  out  NREQ  per-FIFO pop strobe; combinational, at most one bit high.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WIDTH  output word.
- out_src  out  SRCW  index of the requester that supplied out_data.
- out_last  out  1  word is beat MAX_BURST-1 of its grant.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, out_valid=0, out_data=0, out_src=0, out_last=0, req_rden=0, beat_cnt=0.
  - last_grant=NREQ-1, so requester 0 is searched first.
  - Reset mid-burst discards the held output word and the burst state. Nothing is popped in the reset cycle.
- Definition: load_ok = !out_valid || out_ready.
- IDLE state:
  - If any req_empty bit is 0, pick the first non-empty requester searching last_grant+1, last_grant+2, ... modulo NREQ.
  - Register it as grant g, clear beat_cnt, go to BURST.
  - No pop happens in IDLE, so there is one dead cycle per grant.
  - If out_valid=1 and out_ready=1 in IDLE, clear out_valid.
- BURST state, each cycle with load_ok=1 and req_empty[g]=0:
  - req_rden[g]=1 (combinational, same cycle).
  - out_data <= head word of g; out_src <= g; out_valid <= 1; out_last <= (beat_cnt==MAX_BURST-1).
  - Increment beat_cnt.
  - If beat_cnt==MAX_BURST-1: go to IDLE and set last_grant=g.
- BURST state, load_ok=1 and req_empty[g]=1:
  - Burst ends early; no pop.
  - go to IDLE, last_grant=g.
  - If out_ready=1, clear out_valid.
  - No out_last is generated for an early-terminated burst.
- BURST state, load_ok=0 (stall): hold all state, req_rden=0, output registers unchanged.
- Throughput: one word per cycle sustained within a burst while out_ready=1. A word appears on out_valid the cycle after its pop.
- req_rden is never asserted to an empty FIFO, nor when load_ok=0.
- Output registers stay stable while out_valid=1 and out_ready=0.
- beat_cnt is clog2(MAX_BURST)+1 bits wide, so MAX_BURST=256 does not wrap.
- MAX_BURST=1: every word carries out_last=1, and the grant rotates after every word.

Optional Feature:
- Macro: FIFO_RR_ARBITER_PRIO_EN.
- Defined:
  - Adds input port prio_hi [NREQ].
  - In IDLE, if any requester with prio_hi=1 is non-empty, the round-robin search covers only high-priority requesters, starting after last_grant. Otherwise all requesters are searched as normal.
  - prio_hi is sampled only in IDLE; a burst in progress is never preempted.
- Undefined: no prio_hi port; pure round-robin.

Test Plan:
1. Reset, then FIFO0 holds 3 words (A0..A2), other FIFOs empty, out_ready=1 → words A0,A1,A2 with out_src=0 on consecutive cycles starting 2 cycles after reset release; out_last=0 on all; then IDLE and out_valid=0.
2. All 4 FIFOs hold 20 words, MAX_BURST=8, out_ready=1 → grant order 0,1,2,3,0,…, each burst 8 words; out_last=1 on every 8th word; one bubble between bursts.
3. FIFO1 holds 10 words; out_ready toggles 1,0,1,0 → req_rden[1] is never high while out_valid=1 and out_ready=0; out_data stays stable during stalls; all 10 words arrive in order, with no loss or duplication.
4. A burst of 8 is in progress from FIFO2; assert reset after 4 words → next cycle out_valid=0, req_rden=0; after release, requester 0 is searched first and FIFO2 resumes from its 5th word when granted.
5. FIFO3 empties after 5 words with MAX_BURST=8 → 5 words, no out_last, last_grant=3, next grant goes to the lowest non-empty index after 3 (wrapping to 0).
6. With FIFO_RR_ARBITER_PRIO_EN defined: FIFOs 0 and 2 non-empty, prio_hi=4'b0100 → FIFO2 is granted repeatedly until empty, then FIFO0; without the macro → alternates 0,2,0,….

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin burst arbiter draining NREQ first-word-fall-through
// request FIFOs into a single registered valid/ready output stream.
// A grant holds for up to MAX_BURST words and then rotates to the next requester.
// Optional feature macro: FIFO_RR_ARBITER_PRIO_EN (adds prio_hi input; when any
// high-priority requester is non-empty, only high-priority requesters are searched).
module fifo_rr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned SRCW      = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_empty,
  input  logic [NREQ*WIDTH-1:0]  req_dout,
  output logic [NREQ-1:0]        req_rden,
`ifdef FIFO_RR_ARBITER_PRIO_EN
  input  logic [NREQ-1:0]        prio_hi,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRCW-1:0]        out_src,
  output logic                   out_last
);

  // One extra bit so MAX_BURST=256 never wraps the beat counter.
  localparam int unsigned    CNTW      = $clog2(MAX_BURST) + 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);
  localparam logic [SRCW-1:0] LAST_IDX  = SRCW'(NREQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SRCW-1:0]   grant_q, grant_d;
  logic [SRCW-1:0]   last_grant_q, last_grant_d;
  logic [CNTW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SRCW-1:0]   out_src_q, out_src_d;
  logic              out_last_q, out_last_d;

  logic [NREQ-1:0]   avail_c;
  logic [NREQ-1:0]   cand_c;
  logic              pick_found_c;
  logic [SRCW-1:0]   pick_idx_c;
  logic              load_ok_c;
  logic [NREQ-1:0]   rden_c;
  logic [WIDTH-1:0]  head_word_c;

  assign avail_c = ~req_empty;

`ifdef FIFO_RR_ARBITER_PRIO_EN
  // Restrict the search to high-priority requesters whenever one of them has data.
  always_comb begin
    cand_c = avail_c;
    if (|(avail_c & prio_hi)) begin
      cand_c = avail_c & prio_hi;
    end
  end
`else
  // Pure round-robin: every non-empty requester is a candidate.
  always_comb begin
    cand_c = avail_c;
  end
`endif

  // Round-robin search starting one past the previous grant, wrapping modulo NREQ.
  always_comb begin
    int unsigned     idx;
    logic [SRCW-1:0] idx_s;
    idx          = 0;
    idx_s        = '0;
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx   = (32'(last_grant_q) + i) % NREQ;
      idx_s = SRCW'(idx);
      if (!pick_found_c && cand_c[idx_s]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = idx_s;
      end
    end
  end

  // Head word of the currently granted FIFO.
  always_comb begin
    head_word_c = req_dout[32'(grant_q) * WIDTH +: WIDTH];
  end

  // Next-state and output-register logic for the IDLE/BURST controller.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_last_d   = out_last_q;
    rden_c       = '0;
    load_ok_c    = !out_valid_q || out_ready;

    case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        // No pop while granting: this is the one dead cycle per grant.
        if (pick_found_c) begin
          grant_d    = pick_idx_c;
          beat_cnt_d = '0;
          state_d    = S_BURST;
        end
      end

      S_BURST: begin
        if (load_ok_c) begin
          if (!req_empty[grant_q]) begin
            rden_c[grant_q] = 1'b1;
            out_data_d      = head_word_c;
            out_src_d       = grant_q;
            out_valid_d     = 1'b1;
            out_last_d      = (beat_cnt_q == LAST_BEAT);
            beat_cnt_d      = beat_cnt_q + CNTW'(1);
            if (beat_cnt_q == LAST_BEAT) begin
              state_d      = S_IDLE;
              last_grant_d = grant_q;
            end
          end else begin
            // Early end: the held word (if any) is being taken, so the register empties.
            state_d      = S_IDLE;
            last_grant_d = grant_q;
            out_valid_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pop strobe is suppressed in the reset cycle so nothing is lost from the FIFOs.
  assign req_rden = reset ? '0 : rden_c;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed bench for fifo_rr_arbiter with FWFT FIFO models
// and an expected-word scoreboard. Honours FIFO_RR_ARBITER_PRIO_EN if defined.
module tb_fifo_rr_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned SRCW      = 2;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned MAX_BURST = 8;

  typedef struct packed {
    logic [SRCW-1:0]  src;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_empty;
  logic [NREQ*WIDTH-1:0] req_dout;
  logic [NREQ-1:0]       req_rden;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SRCW-1:0]       out_src;
  logic                  out_last;
`ifdef FIFO_RR_ARBITER_PRIO_EN
  logic [NREQ-1:0]       prio_hi;
`endif

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .NREQ(NREQ), .SRCW(SRCW), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_empty(req_empty),
    .req_dout(req_dout),
    .req_rden(req_rden),
`ifdef FIFO_RR_ARBITER_PRIO_EN
    .prio_hi(prio_hi),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_src(out_src),
    .out_last(out_last)
  );

  logic [WIDTH-1:0] fq [NREQ][$];
  beat_t            exp_q [$];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               cyc      = 0;
  int               acc_cnt  = 0;
  logic [NREQ-1:0]  rden_s   = '0;
  logic             gap_chk  = 1'b0;
  logic             have_prev = 1'b0;
  int               prev_cyc = 0;
  logic [SRCW-1:0]  prev_src = '0;
  logic             prev_last = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH+SRCW+1:0] prev_snap = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [WIDTH-1:0] mk(input int s, input int k);
    return {8'hD0, 8'(s), 16'(k)};
  endfunction

  task automatic load(input int s, input int first, input int n);
    for (int k = 0; k < n; k++) fq[s].push_back(mk(s, first + k));
  endtask

  // Expect n words from source s starting at FIFO word 'first', beat numbering from 0 for this grant.
  task automatic expect_burst(input int s, input int first, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.src  = SRCW'(s);
      b.data = mk(s, first + k);
      b.last = (k == int'(MAX_BURST) - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int c = 0; c < budget && (exp_q.size() != 0 || out_valid); c++) tick();
    chk(tag, 64'(exp_q.size()), 64'(0));
    tick();
    tick();
  endtask

  // FWFT FIFO models: pop on the strobes sampled before the edge, then refresh head/empty.
  always @(posedge clk) begin
    cyc++;
    #2;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (rden_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      req_empty[i] = (fq[i].size() == 0);
      req_dout[i*WIDTH +: WIDTH] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  end

  // Monitor: pop-strobe rules, stall stability, scoreboard and inter-burst spacing.
  always @(negedge clk) begin
    beat_t e;
    int    exp_gap;
    rden_s = req_rden;
    if (req_rden != '0) begin
      chk("rden_onehot", 64'($onehot(req_rden)), 64'(1));
      chk("rden_load_ok", 64'(!out_valid || out_ready), 64'(1));
      chk("rden_nonempty", 64'(req_rden & req_empty), 64'(0));
    end
    if (prev_stall) chk("stall_hold", 64'({out_valid, out_src, out_data, out_last}), 64'(prev_snap));
    prev_stall = out_valid && !out_ready && !reset;
    prev_snap  = {out_valid, out_src, out_data, out_last};
    if (out_valid && out_ready) begin
      acc_cnt++;
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_word", 64'({out_src, out_data, out_last}), 64'({e.src, e.data, e.last}));
      end
      if (gap_chk && have_prev) begin
        exp_gap = (out_src == prev_src) ? 1 : (prev_last ? 2 : 3);
        chk("burst_gap", 64'(cyc - prev_cyc), 64'(exp_gap));
      end
      have_prev = 1'b1;
      prev_cyc  = cyc;
      prev_src  = out_src;
      prev_last = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset     = 1'b1;
    out_ready = 1'b1;
    req_empty = '1;
    req_dout  = '0;
`ifdef FIFO_RR_ARBITER_PRIO_EN
    prio_hi   = '0;
`endif

    // Test 1: three words from FIFO0, first word two cycles after reset release.
    tick();
    tick();
    load(0, 0, 3);
    expect_burst(0, 0, 3);
    tick();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_src", 64'(out_src), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_rden", 64'(req_rden), 64'(0));
    reset     = 1'b0;
    have_prev = 1'b0;
    gap_chk   = 1'b1;
    @(negedge clk);
    chk("t1_c0_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("t1_c1_valid", 64'(out_valid), 64'(0));
    chk("t1_c1_rden", 64'(req_rden), 64'(4'b0001));
    @(negedge clk);
    chk("t1_c2_valid", 64'(out_valid), 64'(1));
    wait_drain("t1_drain", 40);
    chk("t1_idle_valid", 64'(out_valid), 64'(0));
    chk("t1_idle_rden", 64'(req_rden), 64'(0));

    // Test 2: all four FIFOs with 20 words; bursts of 8 rotate 0,1,2,3, then a short round.
    do_reset();
    have_prev = 1'b0;
    gap_chk   = 1'b1;
    for (int s = 0; s < int'(NREQ); s++) load(s, 0, 20);
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < int'(NREQ); s++) begin
        expect_burst(s, r * 8, (20 - r * 8 > 8) ? 8 : 20 - r * 8);
      end
    end
    wait_drain("t2_drain", 400);

    // Test 3: FIFO1 with 10 words under a toggling out_ready.
    do_reset();
    gap_chk = 1'b0;
    load(1, 0, 10);
    expect_burst(1, 0, 8);
    exp_q.push_back('{src: SRCW'(1), data: mk(1, 8), last: 1'b0});
    exp_q.push_back('{src: SRCW'(1), data: mk(1, 9), last: 1'b0});
    for (int c = 0; c < 120 && (exp_q.size() != 0 || out_valid); c++) begin
      out_ready = (c % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("t3_drain", 40);

    // Test 4: reset in the middle of a FIFO2 burst; FIFO2 resumes after FIFO0 goes first.
    do_reset();
    gap_chk = 1'b0;
    load(2, 0, 12);
    expect_burst(2, 0, 4);
    base = acc_cnt;
    for (int c = 0; c < 50 && acc_cnt - base < 3; c++) tick();
    reset = 1'b1;
    load(0, 0, 2);
    tick();
    chk("t4_rst_valid", 64'(out_valid), 64'(0));
    chk("t4_rst_rden", 64'(req_rden), 64'(0));
    chk("t4_words_before_rst", 64'(acc_cnt - base), 64'(4));
    chk("t4_fifo2_left", 64'(fq[2].size()), 64'(8));
    reset = 1'b0;
    expect_burst(0, 0, 2);
    expect_burst(2, 4, 8);
    wait_drain("t4_drain", 80);

    // Test 5: FIFO3 ends early after 5 words; the grant then wraps to FIFO0, then FIFO1.
    have_prev = 1'b0;
    gap_chk   = 1'b1;
    load(3, 0, 5);
    load(0, 0, 2);
    load(1, 0, 2);
    expect_burst(3, 0, 5);
    expect_burst(0, 0, 2);
    expect_burst(1, 0, 2);
    wait_drain("t5_drain", 80);

    // Test 6: FIFOs 0 and 2 with 10 words each; order depends on the priority option.
    do_reset();
    gap_chk = 1'b0;
    load(0, 0, 10);
    load(2, 0, 10);
`ifdef FIFO_RR_ARBITER_PRIO_EN
    prio_hi = 4'b0100;
    expect_burst(2, 0, 8);
    expect_burst(2, 8, 2);
    expect_burst(0, 0, 8);
    expect_burst(0, 8, 2);
`else
    expect_burst(0, 0, 8);
    expect_burst(2, 0, 8);
    expect_burst(0, 8, 2);
    expect_burst(2, 8, 2);
`endif
    wait_drain("t6_drain", 120);
    chk("t6_fifo0_empty", 64'(fq[0].size()), 64'(0));
    chk("t6_fifo2_empty", 64'(fq[2].size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
